// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider sequencing arbiter.
// Optional feature macro used by this block: DIV_ZERO_BYPASS_EN.
package div_arb_pkg;

    localparam int unsigned NumReq         = 2;
    localparam int unsigned IdWidth        = 1;
    localparam int unsigned DefaultWidth   = 32;
    localparam int unsigned DefaultTimeout = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-grant pointer moves only on update.
module rr_arbiter2
    import div_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req,
    input  logic              update,
    output logic [NumReq-1:0] grant
);

    logic last_q;
    logic last_d;

    // On contention the requester not granted last time wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    assign last_d = update ? grant[1] : last_q;

    // Reset to "last granted = 1" so requester 0 has priority first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Two-port round-robin front end and sequencer for a shared sequential divider.
// Define DIV_ZERO_BYPASS_EN to answer divisor==0 requests without using the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumReq-1:0]       req_valid,
    output logic [NumReq-1:0]       req_ready,
    input  logic [NumReq*WIDTH-1:0] req_dividend,
    input  logic [NumReq*WIDTH-1:0] req_divisor,
    output logic                    div_run,
    output logic [WIDTH-1:0]        div_dividend,
    output logic [WIDTH-1:0]        div_divisor,
    input  logic                    div_rdy,
    input  logic [WIDTH-1:0]        div_quotient,
    input  logic [WIDTH-1:0]        div_remainder,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IdWidth-1:0]      rsp_id,
    output logic [WIDTH-1:0]        rsp_quotient,
    output logic [WIDTH-1:0]        rsp_remainder,
    output logic                    rsp_err,
    output logic                    rsp_dz
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [NumReq-1:0]   grant;
    logic                hs;
    logic                dz_take;
    logic                timeout_hit;
    logic [IdWidth-1:0]  sel_id;
    logic [WIDTH-1:0]    sel_dividend, sel_divisor;
    logic [IdWidth-1:0]  id_q;
    logic [WIDTH-1:0]    dividend_q, divisor_q;
    logic [WIDTH-1:0]    quo_q, rem_q;
    logic                err_q;
    logic [CntW-1:0]     cnt_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .update (hs),
        .grant  (grant)
    );

    assign hs           = |(req_valid & req_ready);
    assign sel_id       = grant[1];
    assign sel_dividend = sel_id ? req_dividend[WIDTH +: WIDTH] : req_dividend[0 +: WIDTH];
    assign sel_divisor  = sel_id ? req_divisor[WIDTH +: WIDTH] : req_divisor[0 +: WIDTH];
    assign timeout_hit  = (cnt_q == CntMax);

`ifdef DIV_ZERO_BYPASS_EN
    logic dz_q;

    assign dz_take = hs && (sel_divisor == '0);
    assign rsp_dz  = dz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dz_q <= 1'b0;
        end else if (hs) begin
            dz_q <= dz_take;
        end
    end
`else
    assign dz_take = 1'b0;
    assign rsp_dz  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hs) state_d = dz_take ? StResp : StIssue;
            StIssue: state_d = StWait;
            StWait:  if (div_rdy || timeout_hit) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        div_run   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:  req_ready = grant;
            StIssue: div_run = 1'b1;
            StWait:  ;
            StResp:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (hs) begin
                id_q       <= sel_id;
                dividend_q <= sel_dividend;
                divisor_q  <= sel_divisor;
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // div_rdy wins over an expiring watchdog in the same cycle.
            if (state_q == StWait) begin
                if (div_rdy) begin
                    quo_q <= div_quotient;
                    rem_q <= div_remainder;
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    quo_q <= '0;
                    rem_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (dz_take) begin
                quo_q <= '1;
                rem_q <= sel_dividend;
                err_q <= 1'b0;
            end
        end
    end

    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: behavioural divider, response scoreboard, RR model.
module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic        div_run;
    logic [31:0] div_dividend, div_divisor;
    logic        div_rdy;
    logic [31:0] div_quotient, div_remainder;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic        rsp_err, rsp_dz;

    typedef struct {
        logic        id;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   lat      = 3;  // divider latency after div_run; 0 = hung
    int   dv_cnt   = 0;
    logic rr_last  = 1'b1;

    div_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .div_run       (div_run),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_rdy       (div_rdy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .rsp_dz        (rsp_dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic [31:0] dd, input logic [31:0] dv,
                            input logic err);
        exp_t e;
        e.id  = id;
        e.err = err;
        e.dz  = 1'b0;
        if (err) begin
            e.q = '0;
            e.r = '0;
        end else if (dv == 0) begin
            e.q = '1;
            e.r = dd;
`ifdef DIV_ZERO_BYPASS_EN
            e.dz = 1'b1;
`endif
        end else begin
            e.q = dd / dv;
            e.r = dd % dv;
        end
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ops"}, {div_dividend, div_divisor}, 64'd0);
        check({tag, "_res"}, {rsp_quotient, rsp_remainder}, 64'd0);
        check({tag, "_ctl"}, 64'({req_ready, div_run, rsp_valid, rsp_id, rsp_err, rsp_dz}), 64'd0);
    endtask

    // Single requester; returns one edge after the accepting edge.
    task automatic send(input logic id, input logic [31:0] dd, input logic [31:0] dv,
                        input logic err);
        int   k;
        logic acc;
        req_dividend[id*32 +: 32] = dd;
        req_divisor[id*32 +: 32]  = dv;
        req_valid[id] = 1'b1;
        k   = 0;
        acc = 1'b0;
        while (!acc && k < 200) begin
            #1;
            if (req_ready[id]) begin
                push_exp(id, dd, dv, err);
                rr_last = id;
                acc     = 1'b1;
            end
            tick();
            k++;
        end
        req_valid[id] = 1'b0;
        check("accept_bound", 64'(acc), 64'd1);
    endtask

    // Both requesters valid; grant order predicted by a round-robin model.
    task automatic run_both(input logic [31:0] d0, input logic [31:0] v0, input logic [31:0] d1,
                            input logic [31:0] v1, input int n0, input int n1);
        int   p0, p1, c0, c1, acc, k;
        logic w;
        logic [1:0] hsv;
        logic exp_ids[$];
        p0 = n0;
        p1 = n1;
        while (p0 > 0 || p1 > 0) begin
            w = (p0 > 0 && p1 > 0) ? !rr_last : (p0 > 0 ? 1'b0 : 1'b1);
            exp_ids.push_back(w);
            push_exp(w, w ? d1 : d0, w ? v1 : v0, 1'b0);
            if (w) p1--; else p0--;
            rr_last = w;
        end
        req_dividend = {d1, d0};
        req_divisor  = {v1, v0};
        req_valid    = {n1 > 0, n0 > 0};
        c0  = 0;
        c1  = 0;
        acc = 0;
        k   = 0;
        while (req_valid != 2'b00 && k < 400) begin
            #1;
            hsv = req_valid & req_ready;
            if (hsv != 2'b00) begin
                check("grant_order", 64'(hsv[1]), 64'(exp_ids[acc]));
                acc++;
            end
            tick();
            k++;
            if (hsv[0]) begin
                c0++;
                if (c0 == n0) req_valid[0] = 1'b0;
            end
            if (hsv[1]) begin
                c1++;
                if (c1 == n1) req_valid[1] = 1'b0;
            end
        end
        check("both_bound", 64'(k < 400), 64'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Behavioural divider: done stays high until the cycle after the next div_run.
    initial begin
        div_rdy       = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                div_rdy = 1'b0;
                dv_cnt  = 0;
            end else if (div_run) begin
                dv_cnt = (lat == 0) ? -1 : lat;
            end else if (dv_cnt != 0) begin
                div_rdy = 1'b0;
                if (dv_cnt > 0) begin
                    dv_cnt--;
                    if (dv_cnt == 0) begin
                        div_rdy       = 1'b1;
                        div_quotient  = (div_divisor == 0) ? '1 : div_dividend / div_divisor;
                        div_remainder = (div_divisor == 0) ? div_dividend
                                                           : div_dividend % div_divisor;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (rst && rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_qr", {rsp_quotient, rsp_remainder}, {e.q, e.r});
                    check("rsp_flags", 64'({rsp_err, rsp_dz}), 64'({e.err, e.dz}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, runs, v;
        rst          = 1'b0;
        req_valid    = 2'b00;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b1;
        tick();

        // Simultaneous from reset: requester 0 first.
        lat = 3;
        run_both(32'd9, 32'd3, 32'd10, 32'd4, 1, 1);
        drain();

        // Fairness: both held valid over four operations.
        lat = 2;
        run_both(32'd20, 32'd6, 32'd21, 32'd5, 2, 2);
        drain();

        // Single request, divider done 34 cycles after div_run.
        lat = 34;
        send(1'b0, 32'd100, 32'd7, 1'b0);
        runs = int'(div_run);
        n    = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
            if (div_run) runs++;
        end
        check("rsp_latency", 64'(n), 64'd35);
        check("run_pulses", 64'(runs), 64'd1);
        drain();

        // Hung divider: watchdog response after 64 WAIT cycles.
        lat = 0;
        send(1'b1, 32'd77, 32'd7, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("timeout_latency", 64'(n), 64'd65);
        drain();

        // Divisor zero.
        lat = 3;
        send(1'b0, 32'd55, 32'd0, 1'b0);
`ifdef DIV_ZERO_BYPASS_EN
        check("dz_rsp_now", 64'(rsp_valid), 64'd1);
        runs = int'(div_run);
        repeat (5) begin
            tick();
            if (div_run) runs++;
        end
        check("dz_no_run", 64'(runs), 64'd0);
`endif
        drain();

        // Backpressure: response held, new request blocked.
        rsp_ready = 1'b0;
        lat       = 5;
        send(1'b1, 32'd1000, 32'd9, 1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp_latency", 64'(n), 64'd6);
        req_dividend[31:0] = 32'd40;
        req_divisor[31:0]  = 32'd3;
        req_valid[0]       = 1'b1;
        repeat (20) begin
            #1;
            check("bp_data", {rsp_quotient, rsp_remainder}, {32'd111, 32'd1});
            check("bp_ctrl", 64'({rsp_valid, rsp_id, rsp_err, rsp_dz, req_ready, div_run}),
                  64'd96);
            tick();
        end
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b1;
        drain();

        // Reset mid-WAIT aborts without a response.
        lat = 30;
        send(1'b0, 32'd500, 32'd7, 1'b0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check_reset("reset_mid_wait");
        sb.delete();
        rr_last = 1'b1;
        tick();
        rst  = 1'b1;
        runs = 0;
        v    = 0;
        repeat (40) begin
            tick();
            if (rsp_valid) v++;
            if (div_run) runs++;
        end
        check("post_reset_rsp", 64'(v), 64'd0);
        check("post_reset_run", 64'(runs), 64'd0);

        // Pointer back to requester 0 after reset.
        lat = 3;
        run_both(32'd8, 32'd2, 32'd9, 32'd3, 1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
